// File: rtl/fifo_stream_out.sv
// Read-side adapter: turns a registered-read FIFO (rd_en, dout one cycle later, empty)
// into a valid/ready stream through a 2-entry skid buffer so it never overruns downstream.
module fifo_stream_out #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            level
);

  logic [DATA_WIDTH-1:0] head_q, tail_q, head_d, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q;
  logic                  pop;
  logic [1:0]            occ, occ_after_pop, count_after_pop;

  assign out_valid       = (count_q != 2'd0);
  assign out_data        = head_q;
  assign level           = count_q;
  assign pop             = out_valid & out_ready;
  assign occ             = count_q + {1'b0, inflight_q};
  assign occ_after_pop   = occ - {1'b0, pop};
  assign count_after_pop = count_q - {1'b0, pop};

  // Only request a word if a slot is guaranteed free when it lands next cycle.
  assign fifo_rd_en = rst_n & ~fifo_empty & (occ_after_pop < 2'd2);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    if (pop && count_q == 2'd2) head_d = tail_q;
    // The landing word takes the first slot left free after this cycle's pop.
    if (inflight_q) begin
      if (count_after_pop == 2'd0) head_d = fifo_dout;
      else                         tail_d = fifo_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= fifo_rd_en;
    end
  end

`ifdef debug
  logic [2:0] count_wide;
  assign count_wide = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  always @(posedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en && fifo_empty)
        $display("fifo_stream_out ERROR: rd_en asserted while FIFO empty at %0t", $time);
      if (count_wide > 3'd2)
        $display("fifo_stream_out ERROR: buffer count would reach %0d at %0t", count_wide, $time);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Randomized and directed bench for fifo_stream_out: a queue-based upstream FIFO,
// a queue-based model of the output buffer, and an end-to-end order scoreboard.
module tb_fifo_stream_out;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  level;

  fifo_stream_out #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] up_q[$];     // upstream FIFO contents
  logic [31:0] wr_pend[$];  // words written into upstream at the next edge
  logic [31:0] mq[$];       // model of the output buffer, oldest first
  logic [31:0] sent[$];     // every word written, awaiting acceptance downstream
  bit          m_infl = 0;
  bit          rd_prev = 0, pop_prev = 0;
  bit          rdy_next = 0;
  int          cyc = 0;
  int          vcount = 0, vfirst = 0, vlast = 0;
  logic [31:0] firstdata = '0, lastdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: apply last edge's effects to model and upstream, drive, then compare.
  task automatic step();
    bit          exp_valid, exp_rd, exp_pop;
    int          occ_left;
    logic [31:0] word;
    @(negedge clk);
    if (pop_prev) void'(mq.pop_front());
    if (m_infl) mq.push_back(fifo_dout);
    m_infl = rd_prev;
    if (rd_prev) fifo_dout = up_q.pop_front();
    while (wr_pend.size() != 0) up_q.push_back(wr_pend.pop_front());
    fifo_empty = (up_q.size() == 0);
    out_ready  = rdy_next;
    #1;
    exp_valid = (mq.size() != 0);
    exp_pop   = exp_valid && out_ready;
    occ_left  = mq.size() + int'(m_infl) - int'(exp_pop);
    exp_rd    = !fifo_empty && (occ_left < 2);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    chk("level", {30'b0, level}, mq.size());
    chk("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, exp_rd});
    chk("level_max", {31'b0, (level > 2'd2)}, 32'd0);
    if (exp_valid) chk("out_data", out_data, mq[0]);
    if (out_valid && out_ready) begin
      if (sent.size() == 0) chk("spurious_output", 32'd1, 32'd0);
      else begin
        word = sent.pop_front();
        chk("scoreboard", out_data, word);
      end
    end
    if (out_valid) begin
      if (vcount == 0) begin vfirst = cyc; firstdata = out_data; end
      vlast = cyc;
      lastdata = out_data;
      vcount++;
    end
    rd_prev  = exp_rd;
    pop_prev = exp_pop;
    cyc++;
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_pend.push_back(w);
    sent.push_back(w);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    rdy_next = 1;
    while ((sent.size() != 0 || mq.size() != 0 || m_infl) && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (sent.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, required 0", sent.size());
    end
  endtask

  initial begin
    int e0, pushed, guard;

    // Reset state
    #3;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_level", {30'b0, level}, 32'd0);
    chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle, upstream empty
    for (int i = 0; i < 10; i++) step();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);

    // Single word: valid for one cycle, two cycles after empty falls
    vcount = 0; rdy_next = 1;
    write_word(32'hA5A5_0001);
    e0 = cyc;
    for (int i = 0; i < 6; i++) step();
    chk("single_count", vcount, 32'd1);
    chk("single_latency", vfirst - e0, 32'd2);
    chk("single_data", lastdata, 32'hA5A5_0001);
    chk("single_level", {30'b0, level}, 32'd0);

    // Burst of 8, no backpressure: no bubbles after the first word
    vcount = 0;
    for (int i = 0; i < 8; i++) write_word(i);
    e0 = cyc;
    for (int i = 0; i < 14; i++) step();
    chk("burst_count", vcount, 32'd8);
    chk("burst_contig", vlast - vfirst, 32'd7);
    chk("burst_latency", vfirst - e0, 32'd2);
    chk("burst_last", lastdata, 32'd7);

    // Burst of 8 with 6 stalled cycles
    rdy_next = 0;
    for (int i = 0; i < 8; i++) write_word(i);
    for (int i = 0; i < 6; i++) step();
    chk("stall_level", {30'b0, level}, 32'd2);
    chk("stall_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    chk("stall_data", out_data, 32'd0);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_depth", up_q.size(), 32'd6);
    drain(100);

    // Random traffic: 200 words, 50% out_ready
    pushed = 0; guard = 0;
    while ((pushed < 200 || sent.size() != 0) && guard < 4000) begin
      if (pushed < 200 && $urandom_range(1) == 1) begin
        write_word($urandom);
        pushed++;
      end
      rdy_next = ($urandom_range(1) == 1);
      step();
      guard++;
    end
    chk("random_all_sent", pushed, 32'd200);
    chk("random_drained", sent.size(), 32'd0);
    drain(50);

    // Async reset with one word buffered and one in flight
    rdy_next = 0;
    for (int i = 0; i < 4; i++) write_word(32'hBEEF_0000 + i);
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_level", {30'b0, level}, 32'd1);
    chk("pre_rst_infl", {31'b0, m_infl}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_level", {30'b0, level}, 32'd0);
    chk("arst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    mq.delete(); up_q.delete(); sent.delete(); wr_pend.delete();
    m_infl = 0; rd_prev = 0; pop_prev = 0;
    fifo_empty = 1'b1; fifo_dout = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    vcount = 0;
    write_word(32'h0000_1234);
    drain(20);
    chk("post_rst_first", firstdata, 32'h0000_1234);
    chk("post_rst_count", vcount, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
